// File: rtl/lsu_pkg.sv
// Shared types, defaults and access-code helpers for the load/store unit.
package lsu_pkg;

   localparam int LSU_DATA_WIDTH = 32;
   localparam int LSU_ADDR_WIDTH = 32;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT_RSP,
      DONE
   } lsu_state_e;

   // True when the access must be rejected: unknown code or bad alignment.
   function automatic logic acc_bad(
      input logic       st,
      input logic [2:0] f3,
      input logic [1:0] off
   );
      logic legal;
      logic mis;
      legal = 1'b0;
      mis   = 1'b0;
      case (f3)
         F3_B:  legal = 1'b1;
         F3_H:  begin legal = 1'b1; mis = off[0]; end
         F3_W:  begin legal = 1'b1; mis = |off;   end
         F3_BU: legal = !st;
         F3_HU: begin legal = !st;  mis = off[0]; end
         default: legal = 1'b0;
      endcase
      return !legal || mis;
   endfunction

endpackage

// File: rtl/lsu_if.sv
// Word-oriented memory request/response bus between the LSU and memory.
interface lsu_mem_if
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = LSU_DATA_WIDTH,
   parameter int ADDR_WIDTH = LSU_ADDR_WIDTH
);
   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [3:0]            mem_be;
   logic                  mem_gnt;
   logic                  mem_rvalid;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store enables/replication, load lane pick and extend.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = LSU_DATA_WIDTH
) (
   input  logic [1:0]            st_size,
   input  logic [1:0]            st_off,
   input  logic [DATA_WIDTH-1:0] store_data,
   output logic [3:0]            be,
   output logic [DATA_WIDTH-1:0] wdata,
   input  logic [2:0]            ld_funct3,
   input  logic [1:0]            ld_off,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic [DATA_WIDTH-1:0] ld_data
);
   localparam int NB = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] lane;
   logic [7:0]            ld_b;
   logic [15:0]           ld_h;

   always_comb begin
      be    = 4'b1111;
      wdata = store_data;
      case (st_size)
         2'b00: begin
            be    = 4'b0001 << st_off;
            wdata = {NB{store_data[7:0]}};
         end
         2'b01: begin
            be    = 4'b0011 << st_off;
            wdata = {(NB/2){store_data[15:0]}};
         end
         default: ;
      endcase
   end

   assign lane = rdata >> {ld_off, 3'b000};
   assign ld_b = lane[7:0];
   assign ld_h = lane[15:0];

   always_comb begin
      ld_data = lane;
      case (ld_funct3)
         F3_B:  ld_data = {{(DATA_WIDTH-8){ld_b[7]}}, ld_b};
         F3_H:  ld_data = {{(DATA_WIDTH-16){ld_h[15]}}, ld_h};
         F3_BU: ld_data = {{(DATA_WIDTH-8){1'b0}}, ld_b};
         F3_HU: ld_data = {{(DATA_WIDTH-16){1'b0}}, ld_h};
         default: ;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit with ALU pass-through write-back.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = LSU_DATA_WIDTH,
   parameter int ADDR_WIDTH = LSU_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ex_valid,
   output logic                  ex_ready,
   input  logic                  uop_is_mem,
   input  logic                  is_store,
   input  logic [2:0]            funct3,
   input  logic [ADDR_WIDTH-1:0] Mem_addr,
   input  logic [DATA_WIDTH-1:0] store_data,
   input  logic [DATA_WIDTH-1:0] Execution_Result,
   input  logic [4:0]            rd,
   input  logic                  system_stall,
   lsu_mem_if.master             mem,
   output logic                  wb_valid,
   output logic                  wb_we,
   output logic [4:0]            wb_rd,
   output logic [DATA_WIDTH-1:0] wb_data,
   output logic                  misalign_exc
);

   lsu_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [3:0]            be_q, be_d;
   logic                  we_q, we_d;
   logic [2:0]            f3_q, f3_d;
   logic [1:0]            off_q, off_d;
   logic                  pt_q, pt_d;
   logic                  wb_we_q, wb_we_d;
   logic [4:0]            wb_rd_q, wb_rd_d;
   logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
   logic                  mis_q, mis_d;

   logic                  accept;
   logic [3:0]            al_be;
   logic [DATA_WIDTH-1:0] al_wdata;
   logic [DATA_WIDTH-1:0] al_ld;

   lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
      .st_size    (funct3[1:0]),
      .st_off     (Mem_addr[1:0]),
      .store_data (store_data),
      .be         (al_be),
      .wdata      (al_wdata),
      .ld_funct3  (f3_q),
      .ld_off     (off_q),
      .rdata      (mem.mem_rdata),
      .ld_data    (al_ld)
   );

   assign ex_ready = (state_q == IDLE) && !system_stall;
   assign accept   = ex_valid && ex_ready;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      we_d      = we_q;
      f3_d      = f3_q;
      off_d     = off_q;
      pt_d      = 1'b0;
      wb_we_d   = wb_we_q;
      wb_rd_d   = wb_rd_q;
      wb_data_d = wb_data_q;
      mis_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               if (!uop_is_mem) begin
                  pt_d      = 1'b1;
                  wb_we_d   = (rd != 5'd0);
                  wb_rd_d   = rd;
                  wb_data_d = Execution_Result;
               end else if (acc_bad(is_store, funct3,
                                    Mem_addr[1:0])) begin
                  mis_d = 1'b1;
               end else begin
                  state_d = REQ;
                  addr_d  = {Mem_addr[ADDR_WIDTH-1:2], 2'b00};
                  wdata_d = al_wdata;
                  be_d    = al_be;
                  we_d    = is_store;
                  f3_d    = funct3;
                  off_d   = Mem_addr[1:0];
                  wb_rd_d = rd;
               end
            end
         end
         REQ: begin
            if (mem.mem_gnt) begin
               if (we_q) begin
                  state_d   = DONE;
                  wb_we_d   = 1'b0;
                  wb_data_d = '0;
               end else begin
                  state_d = WAIT_RSP;
               end
            end
         end
         WAIT_RSP: begin
            if (mem.mem_rvalid) begin
               state_d   = DONE;
               wb_we_d   = (wb_rd_q != 5'd0);
               wb_data_d = al_ld;
            end
         end
         DONE: begin
            // Stall freezes the completed result in place.
            if (!system_stall) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
         we_q      <= 1'b0;
         f3_q      <= '0;
         off_q     <= '0;
         pt_q      <= 1'b0;
         wb_we_q   <= 1'b0;
         wb_rd_q   <= '0;
         wb_data_q <= '0;
         mis_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         be_q      <= be_d;
         we_q      <= we_d;
         f3_q      <= f3_d;
         off_q     <= off_d;
         pt_q      <= pt_d;
         wb_we_q   <= wb_we_d;
         wb_rd_q   <= wb_rd_d;
         wb_data_q <= wb_data_d;
         mis_q     <= mis_d;
      end
   end

   assign mem.mem_req   = (state_q == REQ);
   assign mem.mem_we    = (state_q == REQ) && we_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;
   assign mem.mem_be    = be_q;

   assign wb_valid     = pt_q || (state_q == DONE);
   assign wb_we        = wb_valid && wb_we_q;
   assign wb_rd        = wb_rd_q;
   assign wb_data      = wb_data_q;
   assign misalign_exc = mis_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, datapath width.
REQ-002 Parameter ADDR_WIDTH, default 32, memory address width.
REQ-003 Port clk  input  1  single clock; all state rises on posedge clk.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port ex_valid  input  1  execution stage presents a uop.
REQ-006 Port ex_ready  output  1  unit accepts uop this cycle.
REQ-007 Port uop_is_mem  input  1  uop is load/store; else pass-through.
REQ-008 Port is_store  input  1  store when 1, load when 0 (valid only with uop_is_mem).
REQ-009 Port funct3  input  3  access size/sign code.
REQ-010 Port Mem_addr  input  ADDR_WIDTH  byte address from execution stage.
REQ-011 Port store_data  input  DATA_WIDTH  unaligned store value (low bytes significant).
REQ-012 Port Execution_Result  input  DATA_WIDTH  ALU result for non-memory uops.
REQ-013 Port rd  input  5  destination register index.
REQ-014 Port system_stall  input  1  global pipeline freeze.
REQ-015 Ports mem_req/mem_we (output 1), mem_addr (output ADDR_WIDTH, word-aligned), mem_wdata (output DATA_WIDTH), mem_be (output 4): memory request.
REQ-016 Ports mem_gnt (input 1) request accepted; mem_rvalid (input 1) and mem_rdata (input DATA_WIDTH) load response.
REQ-017 Ports wb_valid (output 1), wb_we (output 1), wb_rd (output 5), wb_data (output DATA_WIDTH): write-back.
REQ-018 Port misalign_exc  output  1  one-cycle pulse on misaligned/illegal access.

Function
REQ-019 FSM states IDLE, REQ, WAIT_RSP, DONE; reset state IDLE.
REQ-020 ex_ready = 1 only in IDLE with system_stall = 0; accept = ex_valid & ex_ready.
REQ-021 Non-mem accept: next cycle wb_valid=1, wb_we=(rd!=0), wb_data=Execution_Result; FSM stays IDLE; latency 1.
REQ-022 Legal encodings: load funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store 000 SB, 001 SH, 010 SW; others illegal.
REQ-023 Misaligned: halfword with addr[0]=1, word with addr[1:0]!=0; misaligned or illegal accept -> misalign_exc=1 next cycle, no mem_req, wb_valid=0, stay IDLE.
REQ-024 Legal mem accept -> REQ; mem_req=1, mem_addr={addr[ADDR_WIDTH-1:2],2'b00}, mem_we=is_store; all request fields held stable until mem_gnt.
REQ-025 mem_be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; loads drive same mask.
REQ-026 mem_wdata: store_data byte/half replicated across lanes (SB: {4{b}}, SH: {2{h}}).
REQ-027 REQ with mem_gnt: store -> DONE (wb_valid=1, wb_we=0); load -> WAIT_RSP; mem_req deasserts the cycle after gnt.
REQ-028 WAIT_RSP with mem_rvalid -> DONE; wb_data = selected lane of mem_rdata, sign-extended (LB/LH) or zero-extended (LBU/LHU); wb_we=(rd!=0).
REQ-029 mem_rvalid outside WAIT_RSP ignored.
REQ-030 DONE: wb_valid=1 one cycle, then IDLE; if system_stall=1, hold DONE and all wb outputs stable until released.
REQ-031 system_stall does not abort REQ/WAIT_RSP; handshakes continue, only ex_ready and DONE exit freeze.
REQ-032 Back-to-back: non-mem uops accepted every unstalled cycle; mem uop blocks acceptance until DONE exits.
REQ-033 wb_valid and misalign_exc never both 1.

Reset
REQ-034 reset asserted -> immediately IDLE; mem_req, mem_we, mem_be, wb_valid, wb_we, misalign_exc = 0; mem_addr, mem_wdata, wb_data, wb_rd = 0.
REQ-035 reset mid-transaction abandons the access; a later mem_rvalid/mem_gnt is ignored in IDLE.

Structure
REQ-036 Package lsu_pkg holds DATA_WIDTH/ADDR_WIDTH defaults, FSM state type, funct3 encodings.
REQ-037 Sub-module lsu_align: combinational byte-enable, store replication, load lane select and extension.

Verification
REQ-038 Non-mem uop, Execution_Result=0x1234_5678, rd=5 -> next cycle wb_valid=1, wb_data=0x1234_5678, wb_we=1.
REQ-039 LB addr 0x103, mem_rdata=0x80FF_0000, gnt after 2 cycles, rvalid 3 later -> mem_addr=0x100, mem_be=4'b1000, wb_data=0xFFFF_FF80.
REQ-040 SH addr 0x202, store_data=0x0000_ABCD -> mem_be=4'b1100, mem_wdata=0xABCD_ABCD, mem_we=1; DONE wb_valid=1, wb_we=0.
REQ-041 LW addr 0x101 -> misalign_exc pulse 1 cycle, mem_req never 1, ex_ready returns next cycle.
REQ-042 LHU addr 0x2, rdata=0x8001_0000, system_stall=1 during DONE 3 cycles -> wb_data=0x0000_8001 held 4 cycles, wb_valid held.
REQ-043 reset asserted in WAIT_RSP, rvalid arrives after release -> no wb_valid, FSM IDLE.
